// File: rtl/inst_fetch_if.sv
// inst_fetch_if: memory read port and IF/ID handshake of the instruction fetch stage.
//   mem_rd_o     fetch -> arbiter : byte read request
//   mem_addr_o   fetch -> arbiter : byte address of the request
//   mem_grant_i  arbiter -> fetch : request accepted this cycle
//   mem_din_i    memory -> fetch  : read byte, valid the cycle after a grant
//   inst_valid_o fetch -> IF/ID   : inst_o / inst_pc_o valid
//   inst_ready_i IF/ID -> fetch   : instruction accepted
//   inst_o       fetch -> IF/ID   : assembled instruction
//   inst_pc_o    fetch -> IF/ID   : PC of inst_o
// master = fetch stage, slave = memory arbiter / IF/ID side.
interface inst_fetch_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              mem_rd_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_grant_i;
    logic [7:0]        mem_din_i;
    logic              inst_valid_o;
    logic              inst_ready_i;
    logic [31:0]       inst_o;
    logic [ADDR_W-1:0] inst_pc_o;

    modport master (
        output mem_rd_o, mem_addr_o, inst_valid_o, inst_o, inst_pc_o,
        input  mem_grant_i, mem_din_i, inst_ready_i
    );

    modport slave (
        input  mem_rd_o, mem_addr_o, inst_valid_o, inst_o, inst_pc_o,
        output mem_grant_i, mem_din_i, inst_ready_i
    );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: samples the PC, fetches four bytes over the byte-wide memory
// read port, assembles them little-endian and presents the word to IF/ID.
//   clk        clock
//   rst        synchronous active-high reset
//   pc_i       current PC, sampled only in IDLE
//   flush_i    branch redirect; aborts the current fetch
//   stallreq_o fetch busy; pipeline must hold
//   bus        inst_fetch_if master: memory read port + IF/ID handshake
module inst_fetch #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              flush_i,
    output logic              stallreq_o,
    inst_fetch_if.master      bus
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [2:0]        issue_cnt;
    logic [1:0]        recv_cnt;
    logic              pend_q;      // a request was granted last cycle; its byte is on mem_din_i now
    logic [31:0]       data_q;
    logic [31:0]       inst_q;
    logic [ADDR_W-1:0] inst_pc_q;
    logic              valid_q;
    logic              mem_rd;
    logic              last_byte;

    assign last_byte = pend_q && (recv_cnt == 2'd3);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    state_d = FETCH;
                FETCH:   if (last_byte) state_d = HOLD;
                HOLD:    if (valid_q && bus.inst_ready_i) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Combinational outputs; forced low while reset is held so all outputs read zero
    always_comb begin
        stallreq_o = 1'b0;
        mem_rd     = 1'b0;
        if (!rst) begin
            stallreq_o = (state_q != HOLD);
            mem_rd     = (state_q == FETCH) && !issue_cnt[2];
        end
    end

    // Datapath: issue/receive counters, byte assembly, registered outputs.
    // mem_addr_q tracks addr_q + issue_cnt directly so the address output is a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            mem_addr_q <= '0;
            issue_cnt  <= '0;
            recv_cnt   <= '0;
            pend_q     <= 1'b0;
            data_q     <= '0;
            inst_q     <= '0;
            inst_pc_q  <= '0;
            valid_q    <= 1'b0;
        end else if (flush_i) begin
            issue_cnt <= '0;
            recv_cnt  <= '0;
            pend_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    addr_q     <= pc_i;
                    mem_addr_q <= pc_i;
                    issue_cnt  <= '0;
                    recv_cnt   <= '0;
                    pend_q     <= 1'b0;
                end
                FETCH: begin
                    pend_q <= mem_rd && bus.mem_grant_i;
                    if (mem_rd && bus.mem_grant_i) begin
                        issue_cnt  <= issue_cnt + 3'd1;
                        mem_addr_q <= mem_addr_q + 1'b1;
                    end
                    if (pend_q) begin
                        data_q[8*recv_cnt +: 8] <= bus.mem_din_i;
                        recv_cnt                <= recv_cnt + 2'd1;
                    end
                    if (last_byte) begin
                        inst_q    <= {bus.mem_din_i, data_q[23:0]};
                        inst_pc_q <= addr_q;
                        valid_q   <= 1'b1;
                    end
                end
                HOLD: begin
                    if (valid_q && bus.inst_ready_i) valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_rd_o     = mem_rd;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.inst_valid_o = valid_q;
    assign bus.inst_o       = inst_q;
    assign bus.inst_pc_o    = inst_pc_q;

endmodule
